jk_seq_controller: RTL and testbench

- Sequencer and configurator for the 3-bit arbitrary-sequence counter datapath.
- Holds a writable 8-entry next-state table, so any cyclic count order can be programmed at run time instead of rewiring J/K gate logic.
- Supports run, stop, single-step, parallel load and prescaled advance.
- Detects lock-out (entry into an unprogrammed state) and forces recovery to the origin state.

---
 rtl/jk_seq_controller.sv | 174 +++++++++++++++++
 tb/tb_jk_seq_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_controller.sv
// jk_seq_controller: run-time programmable sequencer for a 3-bit counter.
// An 8-entry next-state table replaces fixed J/K gate logic. The controller
// supports run, stop, single-step, parallel load and prescaled advance.
// Entering an unprogrammed state forces recovery to ORIGIN.
// All state updates happen on the falling edge of C. nR is an asynchronous,
// active-low reset.
// Optional feature: define JK_SEQ_LAPS_EN to add the saturating 'laps' output.
module jk_seq_controller #(
  parameter logic [2:0]  ORIGIN = 3'b000,
  parameter int unsigned DIV    = 1
) (
  input  logic       C,
  input  logic       nR,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_next,
  input  logic       wr_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] O,
  output logic       busy,
  output logic       wrap,
  output logic       lockout
`ifdef JK_SEQ_LAPS_EN
  ,
  output logic [7:0] laps
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [2:0]  o_q, o_d;
  logic [7:0]  pre_q, pre_d;
  logic        busy_q, busy_d;
  logic        wrap_q, wrap_d;
  logic        lock_q, lock_d;
  logic        adv;
  logic [2:0]  next_q [8];
  logic [2:0]  next_d [8];
  logic [7:0]  valid_q, valid_d;

  // Table update: a write lands at the edge; the advance reads the old entry
  always_comb begin
    next_d  = next_q;
    valid_d = valid_q;
    if (wr_en) begin
      next_d[wr_addr]  = wr_next;
      valid_d[wr_addr] = wr_valid;
    end
  end

  // Control FSM, prescaler and count advance (load > stop > step > start)
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    lock_d  = 1'b0;
    adv     = 1'b0;
    if (load) begin
      o_d   = load_val;
      pre_d = '0;
    end else if (stop) begin
      state_d = S_IDLE;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (step) begin
            state_d = S_STEP;
            pre_d   = '0;
          end else if (start) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_RUN: begin
          if (pre_q == PRE_LAST) begin
            adv   = 1'b1;
            pre_d = '0;
          end else begin
            pre_d = pre_q + 8'd1;
          end
        end
        S_STEP: begin
          // Single step bypasses the prescaler; start here chains into RUN
          adv     = 1'b1;
          pre_d   = '0;
          state_d = start ? S_RUN : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          pre_d   = '0;
        end
      endcase
      if (adv) begin
        if (valid_q[o_q]) begin
          o_d    = next_q[o_q];
          wrap_d = (next_q[o_q] == ORIGIN);
        end else begin
          o_d    = ORIGIN;
          lock_d = 1'b1;
        end
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // Register bank, falling edge of C with asynchronous clear
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      state_q <= S_IDLE;
      o_q     <= ORIGIN;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lock_q  <= 1'b0;
      valid_q <= '1;
      for (int unsigned i = 0; i < 8; i++) begin
        next_q[i] <= 3'(i + 1);
      end
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      next_q  <= next_d;
    end
  end

  assign O       = o_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;
  assign lockout = lock_q;

`ifdef JK_SEQ_LAPS_EN
  logic [7:0] laps_q, laps_d;

  // Lap counter: counts normal wraps only, saturates, cleared by load
  always_comb begin
    laps_d = laps_q;
    if (load) begin
      laps_d = '0;
    end else if (wrap_d && (laps_q != 8'hFF)) begin
      laps_d = laps_q + 8'd1;
    end
  end

  // Lap counter register
  always_ff @(negedge C or negedge nR) begin
    if (!nR) begin
      laps_q <= '0;
    end else begin
      laps_q <= laps_d;
    end
  end

  assign laps = laps_q;
`endif

endmodule

// File: tb/tb_jk_seq_controller.sv
// Self-checking bench for jk_seq_controller: two instances (DIV=1, DIV=3)
// share the stimulus. A behavioural model predicts every output on every edge.
module tb_jk_seq_controller;

  localparam logic [2:0] ORIGIN = 3'b000;

  logic       C = 1'b1;
  logic       nR;
  logic       wr_en, wr_valid, start, stop, step, load;
  logic [2:0] wr_addr, wr_next, load_val;
  logic [2:0] o1, o3;
  logic       busy1, busy3, wrap1, wrap3, lock1, lock3;
`ifdef JK_SEQ_LAPS_EN
  logic [7:0] laps1, laps3;
`endif

  int checks = 0;
  int errors = 0;

  // model state, index 0 -> DIV=1 instance, index 1 -> DIV=3 instance
  int unsigned m_div  [2] = '{1, 3};
  int unsigned m_mode [2];        // 0 idle, 1 run, 2 step
  int unsigned m_pre  [2];
  int unsigned m_laps [2];
  logic [2:0]  m_o    [2];
  bit          m_wrap [2];
  bit          m_lock [2];
  logic [2:0]  m_next [2][8];
  bit          m_val  [2][8];

  always #5 C = ~C;

  jk_seq_controller #(.ORIGIN(ORIGIN), .DIV(1)) u_div1 (
    .C(C), .nR(nR), .wr_en(wr_en), .wr_addr(wr_addr), .wr_next(wr_next),
    .wr_valid(wr_valid), .start(start), .stop(stop), .step(step),
    .load(load), .load_val(load_val), .O(o1), .busy(busy1), .wrap(wrap1),
    .lockout(lock1)
`ifdef JK_SEQ_LAPS_EN
    , .laps(laps1)
`endif
  );

  jk_seq_controller #(.ORIGIN(ORIGIN), .DIV(3)) u_div3 (
    .C(C), .nR(nR), .wr_en(wr_en), .wr_addr(wr_addr), .wr_next(wr_next),
    .wr_valid(wr_valid), .start(start), .stop(stop), .step(step),
    .load(load), .load_val(load_val), .O(o3), .busy(busy3), .wrap(wrap3),
    .lockout(lock3)
`ifdef JK_SEQ_LAPS_EN
    , .laps(laps3)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pre[k] = 0; m_laps[k] = 0;
      m_o[k] = ORIGIN; m_wrap[k] = 0; m_lock[k] = 0;
      for (int i = 0; i < 8; i++) begin
        m_next[k][i] = 3'((i + 1) % 8);
        m_val[k][i]  = 1'b1;
      end
    end
  endtask

  // One falling edge of the behavioural sequencer
  task automatic m_edge(input int k);
    logic [2:0] cur, nn;
    bit nv, adv;
    cur = m_o[k];
    nn  = m_next[k][cur];
    nv  = m_val[k][cur];
    adv = 0;
    m_wrap[k] = 0;
    m_lock[k] = 0;
    if (load) begin
      m_o[k] = load_val; m_pre[k] = 0; m_laps[k] = 0;
    end else if (stop) begin
      m_mode[k] = 0; m_pre[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (step) begin m_mode[k] = 2; m_pre[k] = 0; end
      else if (start) begin m_mode[k] = 1; m_pre[k] = 0; end
    end else if (m_mode[k] == 1) begin
      if (m_pre[k] == m_div[k] - 1) begin adv = 1; m_pre[k] = 0; end
      else m_pre[k]++;
    end else begin
      adv = 1; m_pre[k] = 0; m_mode[k] = start ? 1 : 0;
    end
    if (adv) begin
      if (nv) begin
        m_o[k] = nn;
        m_wrap[k] = (nn == ORIGIN);
        if (m_wrap[k] && m_laps[k] < 255) m_laps[k]++;
      end else begin
        m_o[k] = ORIGIN;
        m_lock[k] = 1;
      end
    end
    if (wr_en) begin
      m_next[k][wr_addr] = wr_next;
      m_val[k][wr_addr]  = wr_valid;
    end
  endtask

  task automatic compare_all();
    chk("O[div1]",    {5'd0, o1},    {5'd0, m_o[0]});
    chk("O[div3]",    {5'd0, o3},    {5'd0, m_o[1]});
    chk("busy[div1]", {7'd0, busy1}, {7'd0, 1'(m_mode[0] != 0)});
    chk("busy[div3]", {7'd0, busy3}, {7'd0, 1'(m_mode[1] != 0)});
    chk("wrap[div1]", {7'd0, wrap1}, {7'd0, m_wrap[0]});
    chk("wrap[div3]", {7'd0, wrap3}, {7'd0, m_wrap[1]});
    chk("lock[div1]", {7'd0, lock1}, {7'd0, m_lock[0]});
    chk("lock[div3]", {7'd0, lock3}, {7'd0, m_lock[1]});
`ifdef JK_SEQ_LAPS_EN
    chk("laps[div1]", laps1, 8'(m_laps[0]));
    chk("laps[div3]", laps3, 8'(m_laps[1]));
`endif
  endtask

  // Inputs are held across the falling edge, then strobes drop
  task automatic cyc();
    @(negedge C);
    #1;
    m_edge(0);
    m_edge(1);
    compare_all();
    wr_en = 0; start = 0; stop = 0; step = 0; load = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_O1"},   {5'd0, o1},    {5'd0, ORIGIN});
    chk({tag, "_O3"},   {5'd0, o3},    {5'd0, ORIGIN});
    chk({tag, "_busy"}, {6'd0, busy1, busy3}, 8'd0);
    chk({tag, "_wrap"}, {6'd0, wrap1, wrap3}, 8'd0);
    chk({tag, "_lock"}, {6'd0, lock1, lock3}, 8'd0);
`ifdef JK_SEQ_LAPS_EN
    chk({tag, "_laps"}, laps1 | laps3, 8'd0);
`endif
  endtask

  initial begin
    logic [2:0] s2_addr [8] = '{3'd5, 3'd1, 3'd3, 3'd0, 3'd6, 3'd2, 3'd4, 3'd7};
    logic [2:0] s2_next [8] = '{3'd1, 3'd3, 3'd0, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0};
    logic       s2_val  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] s2_seq  [5] = '{3'd1, 3'd3, 3'd0, 3'd6, 3'd5};
    int guard;

    nR = 0; wr_en = 0; wr_addr = 0; wr_next = 0; wr_valid = 0;
    start = 0; stop = 0; step = 0; load = 0; load_val = 0;
    model_reset();
    #2;
    chk_reset_state("reset");
    #10 nR = 1;

    // 1: binary up-count with wrap on 7->0
    start = 1; cyc();
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("s1_O", {5'd0, o1}, 8'(i % 8));
      chk("s1_wrap", {7'd0, wrap1}, {7'd0, 1'(i % 8 == 0)});
      chk("s1_busy", {7'd0, busy1}, 8'd1);
    end
`ifdef JK_SEQ_LAPS_EN
    chk("s1_laps2", laps1, 8'd2);
`endif
    stop = 1; cyc();

    // 2: custom cycle 5,1,3,0,6 with 2,4,7 unprogrammed
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = s2_addr[i]; wr_next = s2_next[i]; wr_valid = s2_val[i];
      cyc();
    end
    load = 1; load_val = 3'd5; cyc();
    chk("s2_load", {5'd0, o1}, 8'd5);
    start = 1; cyc();
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("s2_O", {5'd0, o1}, {5'd0, s2_seq[i % 5]});
      chk("s2_wrap", {7'd0, wrap1}, {7'd0, 1'(s2_seq[i % 5] == 3'd0)});
    end
    stop = 1; cyc();

    // 3: lock-out from unprogrammed state 2
    load = 1; load_val = 3'd2; cyc();
    start = 1; cyc();
    cyc();
    chk("s3_O", {5'd0, o1}, 8'd0);
    chk("s3_lock", {7'd0, lock1}, 8'd1);
    chk("s3_wrap", {7'd0, wrap1}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s3_seq", {5'd0, o1}, {5'd0, s2_seq[(i + 3) % 5]});
      chk("s3_lock_pulse", {7'd0, lock1}, 8'd0);
    end
    stop = 1; cyc();

    // 4: single step from 3
    load = 1; load_val = 3'd3; cyc();
    step = 1; cyc();
    chk("s4_busy_step", {7'd0, busy1}, 8'd1);
    chk("s4_hold", {5'd0, o1}, 8'd3);
    cyc();
    chk("s4_O", {5'd0, o1}, 8'd0);
    chk("s4_busy_done", {7'd0, busy1}, 8'd0);
    cyc();
    chk("s4_O_hold", {5'd0, o1}, 8'd0);

    // 5: prescaled run, then stop+start together
    start = 1; cyc();
    for (int i = 0; i < 10; i++) cyc();
    stop = 1; start = 1; cyc();
    chk("s5_busy", {7'd0, busy3}, 8'd0);
    for (int i = 0; i < 4; i++) cyc();

    // random phase
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_addr  = 3'($urandom);
      wr_next  = 3'($urandom);
      wr_valid = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 3'($urandom);
      stop     = ($urandom_range(0, 15) == 0);
      step     = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 5) == 0);
      cyc();
    end

    // 6: asynchronous reset mid-run at O=6
    @(posedge C); #2 nR = 0; #1;
    model_reset();
    chk_reset_state("s6_pre");
    @(posedge C); #2 nR = 1;
    start = 1; cyc();
    guard = 0;
    while (m_o[0] != 3'd6 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("s6_reach6", {5'd0, o1}, 8'd6);
    #3 nR = 0; #1;
    model_reset();
    chk_reset_state("s6_async");
    @(posedge C); #2 nR = 1;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
